// File: rtl/way_age_tracker.sv
// rtl/way_age_tracker.sv - per-set way age and valid tracking for age-based replacement
module way_age_tracker #(
    parameter int SINGLE_WAY_WIDTH_IN_BITS = 4,
    parameter int NUM_WAY = 16,
    parameter int WAY_INDEX_WIDTH = $clog2(NUM_WAY)
) (
    input  logic                                         clk_in,
    input  logic                                         reset_in,
    input  logic                                         access_valid_in,
    output logic                                         access_ready_out,
    input  logic [1:0]                                   access_op_in,
    input  logic [WAY_INDEX_WIDTH-1:0]                   access_way_in,
    input  logic                                         flush_in,
    output logic                                         flush_busy_out,
    output logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0]  way_flatted_out,
    output logic [NUM_WAY-1:0]                           valid_out
);
    localparam int W = SINGLE_WAY_WIDTH_IN_BITS;
    localparam logic [W-1:0] AGE_MAX = '1;
    localparam logic [WAY_INDEX_WIDTH-1:0] LAST_IDX = WAY_INDEX_WIDTH'(NUM_WAY - 1);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t                     state;
    logic [WAY_INDEX_WIDTH-1:0] sweep_idx;
    logic [W*NUM_WAY-1:0]       age_next;
    logic [NUM_WAY-1:0]         valid_next;
    logic                       accept;
    logic                       way_in_range;
    logic [W-1:0]               age_k;
    logic                       valid_k;

    assign access_ready_out = (state == IDLE) && !flush_in;
    assign accept           = access_valid_in && access_ready_out;
    assign flush_busy_out   = (state == FLUSH);
    assign way_in_range     = {{(32-WAY_INDEX_WIDTH){1'b0}}, access_way_in} < 32'(NUM_WAY);

    always_comb begin
        age_k   = '0;
        valid_k = 1'b0;
        for (int j = 0; j < NUM_WAY; j++) begin
            if (WAY_INDEX_WIDTH'(j) == access_way_in) begin
                age_k   = way_flatted_out[j*W +: W];
                valid_k = valid_out[j];
            end
        end
    end

    // A touched way ages only the valid ways younger than it (all valid ways if it was a miss fill).
    always_comb begin
        age_next   = way_flatted_out;
        valid_next = valid_out;
        if (state == FLUSH) begin
            for (int j = 0; j < NUM_WAY; j++) begin
                if (WAY_INDEX_WIDTH'(j) == sweep_idx) begin
                    age_next[j*W +: W] = '0;
                    valid_next[j]      = 1'b0;
                end
            end
        end else if (accept && way_in_range) begin
            case (access_op_in)
                2'b00: begin
                    for (int j = 0; j < NUM_WAY; j++) begin
                        if (WAY_INDEX_WIDTH'(j) == access_way_in) begin
                            age_next[j*W +: W] = '0;
                            valid_next[j]      = 1'b1;
                        end else if (valid_out[j]
                                     && (!valid_k || way_flatted_out[j*W +: W] < age_k)
                                     && way_flatted_out[j*W +: W] != AGE_MAX) begin
                            age_next[j*W +: W] = way_flatted_out[j*W +: W] + W'(1);
                        end
                    end
                end
                2'b01: begin
                    for (int j = 0; j < NUM_WAY; j++) begin
                        if (WAY_INDEX_WIDTH'(j) == access_way_in) begin
                            age_next[j*W +: W] = '0;
                            valid_next[j]      = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state           <= IDLE;
            sweep_idx       <= '0;
            way_flatted_out <= '0;
            valid_out       <= '0;
        end else begin
            way_flatted_out <= age_next;
            valid_out       <= valid_next;
            case (state)
                IDLE: begin
                    if (flush_in) begin
                        state     <= FLUSH;
                        sweep_idx <= '0;
                    end
                end
                FLUSH: begin
                    if (sweep_idx == LAST_IDX) begin
                        state <= IDLE;
                    end
                    sweep_idx <= sweep_idx + WAY_INDEX_WIDTH'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_way_age_tracker.sv
// tb/tb_way_age_tracker.sv - scoreboard bench for way_age_tracker against a behavioural model
module tb_way_age_tracker;
    localparam int N = 16;
    localparam int W = 4;
    localparam int AMAX = 15;

    logic           clk_in = 1'b0;
    logic           reset_in;
    logic           access_valid_in;
    logic           access_ready_out;
    logic [1:0]     access_op_in;
    logic [3:0]     access_way_in;
    logic           flush_in;
    logic           flush_busy_out;
    logic [W*N-1:0] way_flatted_out;
    logic [N-1:0]   valid_out;

    way_age_tracker #(.SINGLE_WAY_WIDTH_IN_BITS(W), .NUM_WAY(N)) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .access_valid_in(access_valid_in), .access_ready_out(access_ready_out),
        .access_op_in(access_op_in), .access_way_in(access_way_in),
        .flush_in(flush_in), .flush_busy_out(flush_busy_out),
        .way_flatted_out(way_flatted_out), .valid_out(valid_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [N-1:0]   v;
        logic [W*N-1:0] a;
        logic           b;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    int m_age[N];
    bit m_val[N];
    bit m_busy;
    int m_idx;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [W*N-1:0] m_flat();
        logic [W*N-1:0] f = '0;
        for (int i = 0; i < N; i++) f[i*W +: W] = W'(m_age[i]);
        return f;
    endfunction

    function automatic logic [N-1:0] m_valid();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = m_val[i];
        return v;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin m_age[i] = 0; m_val[i] = 0; end
        m_busy = 0;
        m_idx  = 0;
    endfunction

    function automatic void m_touch(int k);
        int old[N];
        for (int i = 0; i < N; i++) old[i] = m_age[i];
        for (int j = 0; j < N; j++) begin
            if (j != k && m_val[j] && (!m_val[k] || old[j] < old[k]))
                m_age[j] = (old[j] + 1 > AMAX) ? AMAX : old[j] + 1;
        end
        m_age[k] = 0;
        m_val[k] = 1;
    endfunction

    function automatic void m_cycle(bit v, bit [1:0] op, int way, bit fl);
        if (m_busy) begin
            m_age[m_idx] = 0;
            m_val[m_idx] = 0;
            m_idx++;
            if (m_idx == N) m_busy = 0;
        end else if (fl) begin
            m_busy = 1;
            m_idx  = 0;
        end else if (v) begin
            if (op == 2'b00) m_touch(way);
            else if (op == 2'b01) begin m_age[way] = 0; m_val[way] = 0; end
        end
    endfunction

    // Drive one cycle of stimulus, predict the post-edge state, return 2 time units after the edge.
    task automatic step(bit v, bit [1:0] op, int way, bit fl);
        exp_t e;
        access_valid_in = v;
        access_op_in    = op;
        access_way_in   = way[3:0];
        flush_in        = fl;
        #1;
        chk("access_ready", {63'd0, access_ready_out}, {63'd0, (!m_busy && !fl)});
        m_cycle(v, op, way, fl);
        e.v = m_valid();
        e.a = m_flat();
        e.b = m_busy;
        sb.push_back(e);
        @(posedge clk_in);
        #2;
    endtask

    always @(posedge clk_in) begin
        #1;
        if (!reset_in && sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("mon_valid", {48'd0, valid_out}, {48'd0, mon_e.v});
            chk("mon_ages", way_flatted_out, mon_e.a);
            chk("mon_busy", {63'd0, flush_busy_out}, {63'd0, mon_e.b});
        end
    end

    initial begin
        reset_in        = 1'b1;
        access_valid_in = 1'b0;
        access_op_in    = 2'b00;
        access_way_in   = 4'd0;
        flush_in        = 1'b0;
        m_reset();
        repeat (3) @(posedge clk_in);
        #2;
        reset_in = 1'b0;

        // 1: reset state
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("rst_ages", way_flatted_out, 64'd0);
        chk("rst_valid", {48'd0, valid_out}, 64'd0);
        chk("rst_busy", {63'd0, flush_busy_out}, 64'd0);

        // 2: two touches then re-touch
        step(1, 0, 3, 0);
        step(1, 0, 5, 0);
        chk("s2_valid", {48'd0, valid_out}, 64'h0028);
        chk("s2_age3", {60'd0, way_flatted_out[12 +: 4]}, 64'd1);
        chk("s2_age5", {60'd0, way_flatted_out[20 +: 4]}, 64'd0);
        step(1, 0, 3, 0);
        chk("s2_age3b", {60'd0, way_flatted_out[12 +: 4]}, 64'd0);
        chk("s2_age5b", {60'd0, way_flatted_out[20 +: 4]}, 64'd1);

        // 3: fill from empty, then hit way 8
        step(0, 0, 0, 1);
        for (int i = 0; i < N; i++) step(0, 0, 0, 0);
        for (int i = 0; i < N; i++) step(1, 0, i, 0);
        chk("s3_fill_ages", way_flatted_out, 64'h0123456789ABCDEF);
        chk("s3_fill_valid", {48'd0, valid_out}, 64'hFFFF);
        step(1, 0, 8, 0);
        chk("s3_hit8", way_flatted_out, 64'h1234567089ABCDEF);

        // 4: invalidate way 0, refill it, then saturation at max age
        step(1, 1, 0, 0);
        chk("s4_inv_valid", {48'd0, valid_out}, 64'hFFFE);
        chk("s4_inv_ages", way_flatted_out, 64'h1234567089ABCDE0);
        step(1, 0, 0, 0);
        chk("s4_refill", way_flatted_out, 64'h234567819ABCDEF0);
        step(1, 1, 2, 0);
        step(1, 0, 2, 0);
        chk("s4_sat_way1", {60'd0, way_flatted_out[4 +: 4]}, 64'hF);
        step(1, 2, 7, 0);
        step(1, 3, 9, 0);

        // 5: flush beats a simultaneous access, sweeps one way per cycle
        step(1, 0, 3, 1);
        for (int i = 0; i < N; i++) begin
            step(($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)), $urandom_range(0, N-1), 1'($urandom_range(0, 1)));
            chk("s5_sweep_valid", {48'd0, valid_out}, {48'd0, 16'(16'hFFFF << (i + 1))});
        end
        chk("s5_done_busy", {63'd0, flush_busy_out}, 64'd0);
        chk("s5_done_ages", way_flatted_out, 64'd0);
        step(1, 0, 1, 0);

        // 6: asynchronous reset in the middle of a sweep
        for (int i = 0; i < N; i++) step(1, 0, i, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        chk("s6_pre_valid", {48'd0, valid_out}, 64'hFFC0);
        access_valid_in = 1'b0;
        flush_in        = 1'b0;
        reset_in        = 1'b1;
        #1;
        chk("s6_rst_valid", {48'd0, valid_out}, 64'd0);
        chk("s6_rst_ages", way_flatted_out, 64'd0);
        chk("s6_rst_busy", {63'd0, flush_busy_out}, 64'd0);
        chk("s6_rst_ready", {63'd0, access_ready_out}, 64'd1);
        m_reset();
        sb.delete();
        @(posedge clk_in);
        #2;
        reset_in = 1'b0;
        step(1, 0, 2, 0);
        chk("s6_after_valid", {48'd0, valid_out}, 64'h0004);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 8), 2'($urandom_range(0, 3)) & (($urandom_range(0, 3) == 0) ? 2'b11 : 2'b01),
                 $urandom_range(0, N-1), ($urandom_range(0, 99) < 2));
        end

        step(0, 0, 0, 0);
        @(posedge clk_in);
        #3;
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
